// File: rtl/character_motion.sv
`default_nettype none
// ============================================================================
//  Module   : character_motion
//  Purpose  : Player sprite motion controller. Turns one-cycle jump/fail
//             requests into per-tick x/y updates along a gravity arc (jumps)
//             or an accelerating drop (fails), and pulses `landed` when the
//             move completes.
//  Options  : CHAR_JUMP_BUFFER_EN - when defined, one request seen while
//             airborne is held and started after the landing IDLE cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module character_motion #(
  parameter int TICK_DIV     = 78_000,
  parameter int X_START      = 355,
  parameter int Y_START      = 454,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 711,
  parameter int STEP_X       = 1,
  parameter int JUMP_V0      = 8,
  parameter int GRAVITY      = 1,
  parameter int FALL_Y_LIMIT = 599
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       module_en,
  input  logic       jump_left,
  input  logic       jump_right,
  input  logic       jump_fail,
  output logic [9:0] char_x,
  output logic [9:0] char_y,
  output logic       fly_flag,
  output logic       char_mirror,
  output logic       busy,
  output logic       landed
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CNT_W-1:0] C_TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic signed [11:0] C_X_MIN   = 12'(X_MIN);
  localparam logic signed [11:0] C_X_MAX   = 12'(X_MAX);
  localparam logic signed [11:0] C_STEP_X  = 12'(STEP_X);
  localparam logic signed [10:0] C_Y_GND   = 11'(Y_START);
  localparam logic signed [10:0] C_Y_FALL  = 11'(FALL_Y_LIMIT);
  localparam logic signed [9:0]  C_GRAV    = 10'(GRAVITY);
  localparam logic signed [7:0]  C_VY_LAUNCH = 8'(-JUMP_V0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_JUMP_R = 2'd1,
    S_JUMP_L = 2'd2,
    S_FALL   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_RIGHT = 2'd1,
    REQ_LEFT  = 2'd2,
    REQ_FAIL  = 2'd3
  } req_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [9:0]        x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic signed [7:0] vy_q, vy_d;
  logic              fly_q, fly_d;
  logic              mirror_q, mirror_d;
  logic              landed_q, landed_d;
`ifdef CHAR_JUMP_BUFFER_EN
  req_t              buf_q, buf_d;
`endif

  logic               w_tick;
  req_t               w_new_req;
  req_t               w_start_req;
  logic signed [10:0] w_y_sum;
  logic [9:0]         w_y_step;
  logic signed [9:0]  w_vy_sum;
  logic signed [7:0]  w_vy_next;
  logic signed [11:0] w_x_ext;
  logic [9:0]         w_x_right;
  logic [9:0]         w_x_left;

  function automatic logic [9:0] clamp_x(input logic signed [11:0] v);
    if (v < C_X_MIN)      return C_X_MIN[9:0];
    else if (v > C_X_MAX) return C_X_MAX[9:0];
    else                  return v[9:0];
  endfunction

  // Datapath helpers: tick strobe, request priority, saturating arithmetic
  always_comb begin
    w_tick = (cnt_q == C_TICK_LAST);

    if (jump_fail)       w_new_req = REQ_FAIL;
    else if (jump_left)  w_new_req = REQ_LEFT;
    else if (jump_right) w_new_req = REQ_RIGHT;
    else                 w_new_req = REQ_NONE;

`ifdef CHAR_JUMP_BUFFER_EN
    w_start_req = (buf_q != REQ_NONE) ? buf_q : w_new_req;
`else
    w_start_req = w_new_req;
`endif

    // y + vy at 11-bit signed width; negative results pin to the top edge
    w_y_sum  = $signed({1'b0, y_q}) + $signed({{3{vy_q[7]}}, vy_q});
    w_y_step = (w_y_sum < 11'sd0) ? 10'd0 : w_y_sum[9:0];

    // vy + gravity saturates to the 8-bit signed range
    w_vy_sum = $signed({{2{vy_q[7]}}, vy_q}) + C_GRAV;
    if (w_vy_sum > 10'sd127)       w_vy_next = 8'sd127;
    else if (w_vy_sum < -10'sd128) w_vy_next = -8'sd128;
    else                           w_vy_next = w_vy_sum[7:0];

    w_x_ext   = $signed({2'b00, x_q});
    w_x_right = clamp_x(w_x_ext + C_STEP_X);
    w_x_left  = clamp_x(w_x_ext - C_STEP_X);
  end

  // Next-state and output logic for the motion FSM
  always_comb begin
    state_d  = state_q;
    cnt_d    = w_tick ? '0 : cnt_q + CNT_W'(1);
    x_d      = x_q;
    y_d      = y_q;
    vy_d     = vy_q;
    fly_d    = fly_q;
    mirror_d = mirror_q;
    landed_d = 1'b0;
`ifdef CHAR_JUMP_BUFFER_EN
    buf_d    = buf_q;
`endif

    if (state_q == S_IDLE) begin
      // Requests are taken on any clk, not just on ticks
      fly_d = 1'b0;
`ifdef CHAR_JUMP_BUFFER_EN
      buf_d = REQ_NONE;
`endif
      case (w_start_req)
        REQ_FAIL:  begin state_d = S_FALL;   vy_d = 8'sd0;       end
        REQ_LEFT:  begin state_d = S_JUMP_L; vy_d = C_VY_LAUNCH; end
        REQ_RIGHT: begin state_d = S_JUMP_R; vy_d = C_VY_LAUNCH; end
        default:   ;
      endcase
    end else begin
`ifdef CHAR_JUMP_BUFFER_EN
      // First request seen while airborne wins and is kept until IDLE
      if (buf_q == REQ_NONE) buf_d = w_new_req;
`endif
      if (w_tick) begin
        fly_d = 1'b1;
        if (state_q == S_FALL) begin
          if (w_y_sum >= C_Y_FALL) begin
            y_d      = C_Y_FALL[9:0];
            landed_d = 1'b1;
            fly_d    = 1'b0;
            state_d  = S_IDLE;
          end else begin
            y_d  = w_y_step;
            vy_d = w_vy_next;
          end
        end else begin
          mirror_d = (state_q == S_JUMP_L);
          x_d      = (state_q == S_JUMP_L) ? w_x_left : w_x_right;
          // Only a descending sprite can touch the ground line
          if ((vy_q > 8'sd0) && (w_y_sum >= C_Y_GND)) begin
            y_d      = C_Y_GND[9:0];
            landed_d = 1'b1;
            fly_d    = 1'b0;
            state_d  = S_IDLE;
          end else begin
            y_d  = w_y_step;
            vy_d = w_vy_next;
          end
        end
      end
    end
  end

  // State registers; disable behaves exactly like reset and drops any flight
  always_ff @(posedge clk) begin
    if (rst || !module_en) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      x_q      <= 10'(X_START);
      y_q      <= 10'(Y_START);
      vy_q     <= 8'sd0;
      fly_q    <= 1'b0;
      mirror_q <= 1'b0;
      landed_q <= 1'b0;
`ifdef CHAR_JUMP_BUFFER_EN
      buf_q    <= REQ_NONE;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vy_q     <= vy_d;
      fly_q    <= fly_d;
      mirror_q <= mirror_d;
      landed_q <= landed_d;
`ifdef CHAR_JUMP_BUFFER_EN
      buf_q    <= buf_d;
`endif
    end
  end

  assign char_x      = x_q;
  assign char_y      = y_q;
  assign fly_flag    = fly_q;
  assign char_mirror = mirror_q;
  assign busy        = (state_q != S_IDLE);
  assign landed      = landed_q;

endmodule
`default_nettype wire

// File: tb/tb_character_motion.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_character_motion
//  Purpose  : Self-checking bench for character_motion: directed scenarios
//             followed by random requests/disables, all compared each cycle
//             against a behavioural model of the motion rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_character_motion;

  localparam int TICK_DIV     = 4;
  localparam int X_START      = 355;
  localparam int Y_START      = 454;
  localparam int X_MIN        = 330;
  localparam int X_MAX        = 380;
  localparam int STEP_X       = 1;
  localparam int JUMP_V0      = 8;
  localparam int GRAVITY      = 1;
  localparam int FALL_Y_LIMIT = 599;
`ifdef CHAR_JUMP_BUFFER_EN
  localparam int BUF_EN = 1;
`else
  localparam int BUF_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, module_en, jump_left, jump_right, jump_fail;
  logic [9:0] char_x, char_y;
  logic       fly_flag, char_mirror, busy, landed;

  character_motion #(
    .TICK_DIV(TICK_DIV), .X_START(X_START), .Y_START(Y_START),
    .X_MIN(X_MIN), .X_MAX(X_MAX), .STEP_X(STEP_X), .JUMP_V0(JUMP_V0),
    .GRAVITY(GRAVITY), .FALL_Y_LIMIT(FALL_Y_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .module_en(module_en),
    .jump_left(jump_left), .jump_right(jump_right), .jump_fail(jump_fail),
    .char_x(char_x), .char_y(char_y), .fly_flag(fly_flag),
    .char_mirror(char_mirror), .busy(busy), .landed(landed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural model: motion mode 0=ground, 1=right arc, 2=left arc, 3=drop
  int m_x, m_y, m_vy, m_cnt, m_mode, m_fly, m_mir, m_landed, m_pend;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic model_reset();
    m_x = X_START; m_y = Y_START; m_vy = 0; m_cnt = 0; m_mode = 0;
    m_fly = 0; m_mir = 0; m_landed = 0; m_pend = 0;
  endtask

  task automatic model_land(input int ground);
    m_y = ground; m_landed = 1; m_fly = 0; m_mode = 0;
  endtask

  task automatic model_physics();
    int s;
    s = m_y + m_vy;
    m_fly = 1;
    if (m_mode == 3) begin
      if (s >= FALL_Y_LIMIT) begin
        model_land(FALL_Y_LIMIT);
        return;
      end
    end else begin
      m_mir = (m_mode == 2) ? 1 : 0;
      m_x   = clampi(m_x + ((m_mode == 2) ? -STEP_X : STEP_X), X_MIN, X_MAX);
      if (m_vy > 0 && s >= Y_START) begin
        model_land(Y_START);
        return;
      end
    end
    m_y  = (s < 0) ? 0 : s;
    m_vy = (m_vy + GRAVITY > 127) ? 127 : m_vy + GRAVITY;
  endtask

  // Advance the model by one clk edge using the inputs the DUT samples
  task automatic model_edge();
    int req;
    bit tk;
    if (rst || !module_en) begin
      model_reset();
      return;
    end
    tk = (m_cnt == TICK_DIV - 1);
    m_cnt = tk ? 0 : m_cnt + 1;
    m_landed = 0;
    req = jump_fail ? 3 : jump_left ? 2 : jump_right ? 1 : 0;
    if (m_mode == 0) begin
      m_fly = 0;
      if (BUF_EN != 0 && m_pend != 0) req = m_pend;
      m_pend = 0;
      if (req != 0) begin
        m_mode = req;
        m_vy   = (req == 3) ? 0 : -JUMP_V0;
      end
    end else begin
      if (BUF_EN != 0 && m_pend == 0) m_pend = req;
      if (tk) model_physics();
    end
  endtask

  task automatic compare_all();
    check("char_x", 32'(char_x), 32'(m_x));
    check("char_y", 32'(char_y), 32'(m_y));
    check("fly_flag", 32'(fly_flag), 32'(m_fly));
    check("char_mirror", 32'(char_mirror), 32'(m_mir));
    check("busy", 32'(busy), 32'(m_mode != 0));
    check("landed", 32'(landed), 32'(m_landed));
  endtask

  // One clock: DUT and model both take the edge, outputs checked on negedge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse(input int which);
    jump_right = (which == 1);
    jump_left  = (which == 2);
    jump_fail  = (which == 3);
    step();
    jump_right = 1'b0; jump_left = 1'b0; jump_fail = 1'b0;
  endtask

  task automatic relaunch_home();
    module_en = 1'b0; step(); module_en = 1'b1; step();
  endtask

  // Run until landed, bounded; returns whether it landed and the min y seen
  task automatic wait_landed(input string tag, output int min_y);
    bit seen;
    seen  = 0;
    min_y = 1023;
    for (int i = 0; i < 400 && !seen; i++) begin
      step();
      if (int'(char_y) < min_y) min_y = int'(char_y);
      if (landed === 1'b1) seen = 1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    int min_y, n_land, nchg, prev_y;
    int ychg[3];
    rst = 1'b1; module_en = 1'b1;
    jump_left = 1'b0; jump_right = 1'b0; jump_fail = 1'b0;
    model_reset();
    repeat (3) step();
    check("reset_x", 32'(char_x), 32'd355);
    check("reset_y", 32'(char_y), 32'd454);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (3) step();

    // Right jump from the default start point
    pulse(1);
    check("rj_busy", 32'(busy), 32'd1);
    wait_landed("rj_landed", min_y);
    check("rj_x", 32'(char_x), 32'd372);
    check("rj_y", 32'(char_y), 32'd454);
    check("rj_apex", 32'(min_y), 32'd418);
    n_land = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (landed === 1'b1) n_land++;
    end
    check("rj_single_landed", 32'(n_land), 32'd0);

    // Fail and right together: fail wins, accelerating drop to the floor
    jump_fail = 1'b1; jump_right = 1'b1; step();
    jump_fail = 1'b0; jump_right = 1'b0;
    nchg = 0; prev_y = int'(char_y);
    for (int i = 0; i < 400 && landed !== 1'b1; i++) begin
      step();
      if (int'(char_y) != prev_y && nchg < 3) begin
        ychg[nchg] = int'(char_y);
        nchg++;
      end
      prev_y = int'(char_y);
    end
    check("fall_landed", 32'(landed), 32'd1);
    check("fall_y1", 32'(ychg[0]), 32'd455);
    check("fall_y2", 32'(ychg[1]), 32'd457);
    check("fall_y3", 32'(ychg[2]), 32'd460);
    check("fall_floor", 32'(char_y), 32'd599);
    check("fall_x_held", 32'(char_x), 32'd372);

    // Disable mid-flight returns straight to the start point
    relaunch_home();
    pulse(1);
    repeat (20) step();
    module_en = 1'b0; step();
    check("abort_x", 32'(char_x), 32'd355);
    check("abort_y", 32'(char_y), 32'd454);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_landed", 32'(landed), 32'd0);
    module_en = 1'b1; step();

    // Two left jumps: the second saturates at X_MIN
    pulse(2);
    wait_landed("lj1_landed", min_y);
    check("lj1_x", 32'(char_x), 32'd338);
    step();
    pulse(2);
    wait_landed("lj2_landed", min_y);
    check("lj2_x_sat", 32'(char_x), 32'd330);
    check("lj2_mirror", 32'(char_mirror), 32'd1);

    // Request while airborne: dropped, or started after one IDLE cycle
    relaunch_home();
    pulse(1);
    repeat (10) step();
    pulse(2);
    wait_landed("mid_landed", min_y);
    step();
    check("mid_req_busy", 32'(busy), 32'(BUF_EN));
    for (int i = 0; i < 400 && busy === 1'b1; i++) step();
    check("mid_drained", 32'(busy), 32'd0);

    // Random requests, disables and resets against the model
    for (int i = 0; i < 5000; i++) begin
      jump_fail  = ($urandom_range(0, 59) == 0);
      jump_left  = ($urandom_range(0, 29) == 0);
      jump_right = ($urandom_range(0, 29) == 0);
      module_en  = ($urandom_range(0, 399) != 0);
      rst        = ($urandom_range(0, 999) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
